// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the NOP instruction constant, instruction field bit positions, and the
// opcode classes that read rs2.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hazard_state_e;

  localparam logic [15:0] NOP_INSTR = 16'hFFFF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;

  // Register-register ALU ops occupy opcodes 0..3; stores also read rs2.
  localparam logic [3:0] OP_ALU_RR_LAST = 4'h3;
  localparam logic [3:0] OP_STORE       = 4'h9;

  function automatic logic uses_rs2(input logic [3:0] opc);
    return (opc <= OP_ALU_RR_LAST) || (opc == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter
// Saturating event counter: counts cycles with en=1 and sticks at all-ones.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, clears the count
//   en     in   count this cycle
//   count  out  PERF_W-bit current count
module hazard_perf_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  // Increment only while below the saturation value.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {PERF_W{1'b1}})) begin
      count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Drives PC / IF-ID / ID-EX stall and flush controls and freezes the back end
// on data-memory wait states. Sequences load-use bubbles, branch flushes and
// memory freezes with a small FSM (RUN, LOAD_STALL, MEM_WAIT) and a bubble
// counter. All control outputs are combinational from state and inputs.
// Optional feature macro: HAZARD_PERF_EN builds the saturating stall/flush
// performance counters; without it stall_cycles and flush_count read 0.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   id_instr                   instruction in IF/ID (16'hFFFF = NOP)
//   ex_mem_read, ex_rd         load flag and destination of the EX instruction
//   branch_taken               taken branch resolved in EX this cycle
//   mem_req, mem_ready         data-memory handshake of the MEM stage
//   pc_write_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall  controls
//   stall_cycles, flush_count  performance counters
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_W            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       id_instr,
  input  logic              ex_mem_read,
  input  logic [2:0]        ex_rd,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write_en,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_STALL_CYCLES - 1);

  hazard_state_e state_q, state_d;
  hazard_state_e ret_state_q, ret_state_d;
  hazard_state_e eff_state;
  logic [1:0]    bubble_cnt_q, bubble_cnt_d;

  logic [3:0] opcode;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;
  logic       mem_busy;
  logic       hold;

  assign opcode = id_instr[OPC_MSB:OPC_LSB];
  assign rs1    = id_instr[RS1_MSB:RS1_LSB];
  assign rs2    = id_instr[RS2_MSB:RS2_LSB];

  // R0 never creates a dependence; rs2 only matters for opcodes that read it.
  assign rs1_hit  = (rs1 == ex_rd) && (rs1 != 3'd0);
  assign rs2_hit  = uses_rs2(opcode) && (rs2 == ex_rd) && (rs2 != 3'd0);
  assign load_use = ex_mem_read && (id_instr != NOP_INSTR) && (rs1_hit || rs2_hit);
  assign mem_busy = mem_req && !mem_ready;

  // In MEM_WAIT the release is keyed on mem_ready alone, and on release the
  // saved state's ordinary behaviour is replayed in the same cycle.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_state_q : state_q;
  assign hold      = (state_q == ST_MEM_WAIT) ? !mem_ready : mem_busy;

  // Next-state and Mealy control outputs. Priority: memory freeze, then
  // branch flush, then load-use bubble. Stall and flush land on different
  // registers, so the two never collide.
  always_comb begin
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    bubble_cnt_d = bubble_cnt_q;
    pc_write_en  = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;

    if (reset) begin
      pc_write_en = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hold) begin
      pc_write_en  = 1'b0;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        ret_state_d = state_q;
      end
      state_d = ST_MEM_WAIT;
    end else begin
      state_d = eff_state;
      case (eff_state)
        ST_LOAD_STALL: begin
          // EX holds a bubble here, so branch_taken cannot be genuine.
          pc_write_en  = 1'b0;
          if_id_stall  = 1'b1;
          id_ex_flush  = 1'b1;
          bubble_cnt_d = bubble_cnt_q - 2'd1;
          if (bubble_cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write_en = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d      = ST_LOAD_STALL;
              bubble_cnt_d = BUBBLE_INIT;
            end
          end
        end
      endcase
    end
  end

  // FSM state, return state and remaining bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      ret_state_q  <= ST_RUN;
      bubble_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_event;
  logic flush_event;

  // Outside reset, if_id_flush is asserted only by a branch flush.
  assign stall_event = !reset && !pc_write_en;
  assign flush_event = !reset && if_id_flush;

  hazard_perf_counter #(.PERF_W(PERF_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (stall_event),
    .count (stall_cycles)
  );

  hazard_perf_counter #(.PERF_W(PERF_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (flush_event),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
// Drives two hazard_control_unit instances in lockstep from shared inputs:
// one with 2 load-use bubbles and 16-bit counters, one with 3 bubbles and
// 4-bit counters (so saturation is reachable). Control outputs are packed as
// {pc_write_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}.
module tb_hazard_control_unit;

  typedef struct {
    logic [15:0] instr;
    logic        mem_read;
    logic [2:0]  rd;
    logic        br;
    logic        req;
    logic        rdy;
    logic [4:0]  exp2;
    logic [4:0]  exp3;
    string       name;
  } vec_t;

  typedef struct {
    logic [4:0] exp2;
    logic [4:0] exp3;
    string      name;
  } exp_t;

  localparam logic [4:0] IDLE = 5'b10000;
  localparam logic [4:0] FRZ  = 5'b01001;
  localparam logic [4:0] LU   = 5'b01010;
  localparam logic [4:0] BR   = 5'b10110;
  localparam logic [4:0] RST  = 5'b00110;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] id_instr;
  logic        ex_mem_read;
  logic [2:0]  ex_rd;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_we2, ifs2, iff2, idf2, exs2;
  logic        pc_we3, ifs3, iff3, idf3, exs3;
  logic [15:0] stall_cycles2, flush_count2;
  logic [3:0]  stall_cycles3, flush_count3;
  logic [4:0]  out2, out3;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   stall2 = 0, stall3 = 0, flush2 = 0, flush3 = 0;

  assign out2 = {pc_we2, ifs2, iff2, idf2, exs2};
  assign out3 = {pc_we3, ifs3, iff3, idf3, exs3};

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_STALL_CYCLES(2), .PERF_W(16)) dut_n2 (
    .clk (clk), .reset (reset), .id_instr (id_instr), .ex_mem_read (ex_mem_read),
    .ex_rd (ex_rd), .branch_taken (branch_taken), .mem_req (mem_req), .mem_ready (mem_ready),
    .pc_write_en (pc_we2), .if_id_stall (ifs2), .if_id_flush (iff2), .id_ex_flush (idf2),
    .ex_mem_stall (exs2), .stall_cycles (stall_cycles2), .flush_count (flush_count2)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .PERF_W(4)) dut_n3 (
    .clk (clk), .reset (reset), .id_instr (id_instr), .ex_mem_read (ex_mem_read),
    .ex_rd (ex_rd), .branch_taken (branch_taken), .mem_req (mem_req), .mem_ready (mem_ready),
    .pc_write_en (pc_we3), .if_id_stall (ifs3), .if_id_flush (iff3), .id_ex_flush (idf3),
    .ex_mem_stall (exs3), .stall_cycles (stall_cycles3), .flush_count (flush_count3)
  );

  function automatic int satInc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic compareOut(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic compareVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [15:0] instr, input logic mr, input logic [2:0] rd,
                        input logic br, input logic req, input logic rdy,
                        input logic [4:0] e2, input logic [4:0] e3, input string name);
    vec_t v;
    v.instr = instr; v.mem_read = mr; v.rd = rd; v.br = br;
    v.req = req; v.rdy = rdy; v.exp2 = e2; v.exp3 = e3; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic driveIdle();
    id_instr = 16'hFFFF; ex_mem_read = 1'b0; ex_rd = 3'd0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    id_instr = v.instr; ex_mem_read = v.mem_read; ex_rd = v.rd;
    branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
    e.exp2 = v.exp2; e.exp3 = v.exp3; e.name = v.name;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #3;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      compareOut({e.name, "/n2"}, out2, e.exp2);
      compareOut({e.name, "/n3"}, out3, e.exp3);
      if (!e.exp2[4]) stall2 = satInc(stall2, 65535);
      if (!e.exp3[4]) stall3 = satInc(stall3, 15);
      if (e.exp2[2])  flush2 = satInc(flush2, 65535);
      if (e.exp3[2])  flush3 = satInc(flush3, 15);
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef HAZARD_PERF_EN
    compareVal({tag, "_stall_n2"}, int'(stall_cycles2), stall2);
    compareVal({tag, "_stall_n3"}, int'(stall_cycles3), stall3);
    compareVal({tag, "_flush_n2"}, int'(flush_count2), flush2);
    compareVal({tag, "_flush_n3"}, int'(flush_count3), flush3);
`else
    compareVal({tag, "_stall_n2"}, int'(stall_cycles2), 0);
    compareVal({tag, "_stall_n3"}, int'(stall_cycles3), 0);
    compareVal({tag, "_flush_n2"}, int'(flush_count2), 0);
    compareVal({tag, "_flush_n3"}, int'(flush_count3), 0);
`endif
  endtask

  initial begin
    // Sequential vector table; state carries from row to row.
    addVec(16'h5658, 1, 3'd3, 0, 0, 0, IDLE, IDLE, "rs2_unused_op5");
    addVec(16'h0658, 1, 3'd0, 0, 0, 0, IDLE, IDLE, "ex_rd_zero");
    addVec(16'hFFFF, 1, 3'd7, 0, 0, 0, IDLE, IDLE, "nop_no_hazard");
    addVec(16'h5000, 1, 3'd0, 0, 0, 0, IDLE, IDLE, "rs1_r0");
    addVec(16'h0658, 0, 3'd3, 0, 0, 0, IDLE, IDLE, "not_a_load");
    addVec(16'h0658, 1, 3'd3, 1, 0, 0, BR,   BR,   "branch_beats_load_use");
    addVec(16'h0658, 1, 3'd3, 0, 0, 0, LU,   LU,   "load_use_rs2_b1");
    addVec(16'hFFFF, 0, 3'd0, 1, 0, 0, LU,   LU,   "bubble2_branch_ignored");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, LU,   "bubble3");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "after_bubbles");
    addVec(16'h9658, 1, 3'd3, 0, 0, 0, LU,   LU,   "store_rs2_b1");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ,  FRZ,  "ls_mem_freeze1");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ,  FRZ,  "ls_mem_freeze2");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 1, LU,   LU,   "ls_mem_release");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, LU,   "ls_last_bubble");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "ls_done");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ,  FRZ,  "mem_wait1");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ,  FRZ,  "mem_wait2");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ,  FRZ,  "mem_wait3");
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 1, IDLE, IDLE, "mem_release");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "mem_back_run");
    addVec(16'h50C0, 1, 3'd3, 0, 1, 0, FRZ,  FRZ,  "mem_beats_load_use");
    addVec(16'h50C0, 1, 3'd3, 0, 1, 1, LU,   LU,   "release_into_load_use");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, LU,   LU,   "rs1_bubble2");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, LU,   "rs1_bubble3");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "rs1_done");
    addVec(16'hFFFF, 0, 3'd0, 1, 1, 0, FRZ,  FRZ,  "mem_beats_branch");
    addVec(16'hFFFF, 0, 3'd0, 1, 1, 1, BR,   BR,   "release_into_branch");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "branch_done");
    for (int i = 0; i < 20; i++) begin
      addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ, FRZ, "long_freeze");
    end
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 1, IDLE, IDLE, "long_release");
    addVec(16'hFFFF, 0, 3'd0, 0, 0, 0, IDLE, IDLE, "long_done");

    // Power-on reset.
    driveIdle();
    reset = 1'b1;
    #3;
    compareOut("reset_outputs/n2", out2, RST);
    compareOut("reset_outputs/n3", out3, RST);
    checkCounters("reset");
    #5;
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Counters after the table, including saturation of the 4-bit ones.
    @(posedge clk);
    #1;
    driveIdle();
    #3;
    checkCounters("perf");

    // Reset asserted mid-cycle while bubbles are still pending.
    addVec(16'h0658, 1, 3'd3, 0, 0, 0, LU, LU, "pre_reset_load_use");
    applyStimulus(vecs[vecs.size()-1]);
    checkOutput();
    @(posedge clk);
    #1;
    driveIdle();
    #1;
    reset = 1'b1;
    stall2 = 0; stall3 = 0; flush2 = 0; flush3 = 0;
    #1;
    compareOut("reset_mid_ls/n2", out2, RST);
    compareOut("reset_mid_ls/n3", out3, RST);
    checkCounters("reset_mid");
    @(posedge clk);
    #1;
    compareOut("reset_held/n2", out2, RST);
    compareOut("reset_held/n3", out3, RST);
    #1;
    reset = 1'b0;
    #1;
    compareOut("bubbles_discarded/n2", out2, IDLE);
    compareOut("bubbles_discarded/n3", out3, IDLE);

    // Reset asserted mid-MEM_WAIT.
    addVec(16'hFFFF, 0, 3'd0, 0, 1, 0, FRZ, FRZ, "pre_reset_freeze");
    applyStimulus(vecs[vecs.size()-1]);
    checkOutput();
    @(posedge clk);
    #1;
    #1;
    reset = 1'b1;
    #1;
    compareOut("reset_mid_mw/n2", out2, RST);
    compareOut("reset_mid_mw/n3", out3, RST);
    #1;
    reset = 1'b0;
    mem_req = 1'b0;
    #1;
    compareOut("mw_discarded/n2", out2, IDLE);
    compareOut("mw_discarded/n3", out3, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
